// File: rtl/blink_pkg.sv
// blink_pkg: shared constants for the blink sequencer slice.
//   ST_IDLE / ST_ARM / ST_RUN : FSM state encoding
//   DEF_PAT_LEN / DEF_REP_W   : default pattern length and repeat-field width
package blink_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int DEF_PAT_LEN = 16;
    localparam int DEF_REP_W   = 8;

endpackage

// File: rtl/blink_sequencer_if.sv
// blink_sequencer_if: pattern-load handshake between control logic and sequencer.
//   pat_data  : pattern bits, bit 0 played first
//   pat_len   : bits per pass (0 or > PAT_LEN means PAT_LEN)
//   pat_reps  : passes to play (0 = forever)
//   pat_valid : load request from control logic
//   pat_ready : sequencer can accept a pattern
// Modports: master = control logic, slave = sequencer.
interface blink_sequencer_if
    import blink_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int LEN_W   = $clog2(PAT_LEN + 1),
    parameter int REP_W   = DEF_REP_W
);
    logic [PAT_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;
    logic [REP_W-1:0]   pat_reps;
    logic               pat_valid;
    logic               pat_ready;

    modport master (output pat_data, pat_len, pat_reps, pat_valid, input pat_ready);
    modport slave  (input pat_data, pat_len, pat_reps, pat_valid, output pat_ready);
endinterface

// File: rtl/blink_sequencer_rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of a synchronous input.
//   clk, rst : clock, asynchronous active-high reset
//   in       : level input (synchronous to clk)
//   pulse    : in & ~in_delayed, combinational
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic r_in_q;

    // Delay the input by one clock for edge comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign pulse = in & ~r_in_q;
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: plays a loaded bit pattern on one LED, one bit per rising
// edge of blink, for a programmed number of passes.
//   clk, rst : clock, asynchronous active-high reset
//   blink    : step source; each rising edge advances one bit
//   abort    : stop playback immediately (ignored in IDLE)
//   pat_if   : pattern-load handshake (slave side)
//   led      : registered LED drive
//   busy     : high while armed or running
//   done     : one-cycle pulse when the final pass completes
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int LEN_W   = $clog2(PAT_LEN + 1),
    parameter int REP_W   = DEF_REP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blink,
    input  logic                   abort,
    blink_sequencer_if.slave       pat_if,
    output logic                   led,
    output logic                   busy,
    output logic                   done
);
    logic [1:0]         r_state;
    logic               r_led;
    logic               r_done;
    logic               r_busy;
    logic               r_ready;
    logic [PAT_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [REP_W-1:0]   r_reps_left;
    logic               r_forever;

    logic               w_tick;
    logic               w_accept;
    logic               w_arm_tick;
    logic               w_run_tick;
    logic               w_last;
    logic               w_more;
    logic               w_step;
    logic               w_wrap;
    logic               w_abort;
    logic [LEN_W-1:0]   w_next_idx;
    logic [PAT_LEN-1:0] w_shifted;
    logic [LEN_W-1:0]   w_len_clamped;

    rise_detect u_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (blink),
        .pulse (w_tick)
    );

    assign w_len_clamped = ((pat_if.pat_len == {LEN_W{1'b0}}) ||
                            (pat_if.pat_len > LEN_W'(PAT_LEN))) ? LEN_W'(PAT_LEN)
                                                                 : pat_if.pat_len;

    // Abort only matters once armed; it also outranks a same-cycle tick.
    assign w_abort    = abort & (r_state != ST_IDLE);
    assign w_accept   = (r_state == ST_IDLE) & pat_if.pat_valid;
    assign w_arm_tick = (r_state == ST_ARM) & w_tick & ~abort;
    assign w_run_tick = (r_state == ST_RUN) & w_tick & ~abort;
    assign w_last     = (r_idx == (r_len - LEN_W'(1)));
    assign w_more     = r_forever | (r_reps_left > REP_W'(1));
    assign w_step     = w_run_tick & ~w_last;
    assign w_wrap     = w_run_tick & w_last & w_more;
    assign w_next_idx = r_idx + LEN_W'(1);
    // Shift instead of a variable bit-select so the index width never matters.
    assign w_shifted  = r_pat >> w_next_idx;

    // Control FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_led   <= 1'b0;
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_state <= ST_ARM;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (w_arm_tick) begin
                            r_led   <= r_pat[0];
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_step) begin
                            r_led <= w_shifted[0];
                        end else if (w_wrap) begin
                            r_led <= r_pat[0];
                        end else if (w_run_tick) begin
                            r_led   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Pattern, length, bit index and pass counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat       <= {PAT_LEN{1'b0}};
            r_len       <= {LEN_W{1'b0}};
            r_idx       <= {LEN_W{1'b0}};
            r_reps_left <= {REP_W{1'b0}};
            r_forever   <= 1'b0;
        end else if (w_accept) begin
            r_pat       <= pat_if.pat_data;
            r_len       <= w_len_clamped;
            r_idx       <= {LEN_W{1'b0}};
            r_reps_left <= pat_if.pat_reps;
            r_forever   <= (pat_if.pat_reps == {REP_W{1'b0}});
        end else if (w_arm_tick) begin
            r_idx <= {LEN_W{1'b0}};
        end else if (w_step) begin
            r_idx <= w_next_idx;
        end else if (w_wrap) begin
            r_idx <= {LEN_W{1'b0}};
            if (!r_forever) begin
                r_reps_left <= r_reps_left - REP_W'(1);
            end
        end
    end

    assign led              = r_led;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pat_if.pat_ready = r_ready;
endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Downstream consumer of the blinker's `blink` square wave. Each rising edge of `blink` is one step tick. The block plays a loaded bit pattern on a single LED, one bit per tick, for a programmed number of passes. Patterns are accepted through a valid/ready handshake from the control logic.

## Interface
Parameters:
- `PAT_LEN`, 16: maximum pattern length in bits; must be ≥ 2.
- `LEN_W`, `$clog2(PAT_LEN+1)`: width of the length field.
- `REP_W`, 8: width of the repeat field.

Ports:
- `clk` in 1: single clock; `blink` is synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `blink` in 1: square wave from the blinker; each rising edge is one step tick.
- `pat_data` in `PAT_LEN`: pattern; bit 0 is played first.
- `pat_len` in `LEN_W`: number of bits to play; 0 or > `PAT_LEN` clamps to `PAT_LEN`.
- `pat_reps` in `REP_W`: number of passes; 0 = loop forever.
- `pat_valid` in 1: load request.
- `pat_ready` out 1: high only in IDLE.
- `abort` in 1: stop playback immediately.
- `led` out 1: registered LED drive.
- `busy` out 1: high in ARM and RUN.
- `done` out 1: one-cycle pulse when the final pass completes.

## Operation
- Tick detect: `blink_q` is `blink` registered, reset 0; `tick = blink & ~blink_q`.
- State IDLE:
  - `pat_ready=1`, `led=0`.
  - On `pat_valid`: latch `pat_data`, clamped length `len`, `reps_left = pat_reps`, and `forever = (pat_reps==0)`; go to ARM.
  - `abort` has no effect in IDLE; a same-cycle handshake still completes.
  - `tick` is ignored.
- State ARM: on `tick`, `led <= pat[0]`, `idx <= 0`; go to RUN.
- State RUN, on `tick`:
  - If `idx != len-1`: `idx <= idx+1`, `led <= pat[idx+1]`.
  - If `idx == len-1` and (`forever` or `reps_left > 1`): wrap `idx <= 0`, `led <= pat[0]`, and decrement `reps_left` unless `forever`.
  - If `idx == len-1` and not `forever` and `reps_left == 1`: `led <= 0`, `done <= 1` for one cycle, go to IDLE.
- `abort` in ARM or RUN: next cycle `led=0`, state IDLE, no `done` pulse.
- `abort` takes priority over a same-cycle `tick`.
- `pat_valid` while busy is ignored; no queuing.
- Each bit is held exactly one `blink` period, from rising edge to rising edge.
- Arithmetic: `idx` is `LEN_W` bits and `reps_left` is `REP_W` bits, both unsigned, with no overflow paths.

## Timing
- Reset values: `led=0`, `busy=0`, `done=0`, `pat_ready=1`, state IDLE, `blink_q=0`, `idx=0`, `reps_left=0`.
- Handshake: `pat_ready` drops the cycle after acceptance; `busy` rises the same cycle.
- Tick latency: `blink` rises at cycle N → `tick` at N → `led` updates at N+1.
- `done` is asserted at N+1 of the final tick; `pat_ready` returns high in that same cycle.
- A new pattern can be accepted in the cycle after `done`.
- `len == 1`: every tick is a pass boundary. One pass ends on the second tick after load, because the first tick only starts playback.
- `rst` mid-playback: outputs return to their reset values immediately, asynchronously.

## Structure
- Package `blink_pkg`: state encoding localparams (`ST_IDLE`, `ST_ARM`, `ST_RUN`) and the default `PAT_LEN`/`REP_W`.
- Sub-module `rise_detect` (clk, rst, in, pulse): reused by other blink consumers.
- Everything else lives in one FSM block plus a datapath register block.

## Test plan
All cases drive `blink` with period 8 clocks (4 high, 4 low).
- Reset then idle: `led=0`, `pat_ready=1`, `busy=0`; `tick`s are ignored.
- Load `pat_data=16'h000B`, `pat_len=4`, `pat_reps=2` → `led` sequence 1,1,0,1,1,1,0,1, each held 8 clocks, then `done` for one cycle and `led=0`; exactly 8 ticks after ARM.
- `pat_reps=0`, `pat_len=3`, pattern `3'b101` → loops 1,0,1 for at least 5 passes with no `done`; `abort` mid-bit → `led=0` next cycle, `pat_ready=1`, no `done`.
- `pat_len=0` and `pat_len=20` with `PAT_LEN=16` → both play 16 bits per pass.
- Edge cases:
  - `abort` coincident with `tick` → abort wins.
  - `pat_valid` while busy → ignored.
  - `pat_valid` with `abort` in IDLE → accepted.
  - `len=1`, `reps=1` → `led` is `pat[0]` for one period, then `done`.
- Async `rst` pulsed mid-RUN, away from a clock edge → `led=0`, `busy=0` before the next edge; normal load works afterwards.
